coin_dispenser: RTL and testbench
=================================

Name: coin_dispenser

Overview:
- Downstream of the vending-machine top's change computation: consumes the greedy per-denomination change counts (quarters/dimes/nickels/pennies).
- Physically dispenses the coins one at a time by pulsing one solenoid-style eject line per coin.
- Reports progress (cents dispensed so far), busy/done status, and abort status.
- Decouples the combinational change result from slow mechanical timing.

Parameters:
- PULSE_CYC, 2500000: clock cycles each eject line is held high per coin (50 ms at 50 MHz); legal range ≥ 1.
- GAP_CYC, 2500000: clock cycles all eject lines are held low between coins; legal range ≥ 1.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request to dispense; sampled only in IDLE.
- abort  input  1  cancel an in-progress transaction.
- quarters  input  4  quarter count; snapshotted on start accept.
- dimes  input  4  dime count; snapshotted on start accept.
- nickels  input  4  nickel count; snapshotted on start accept.
- pennies  input  4  penny count; snapshotted on start accept.
- eject_q  output  1  quarter eject pulse.
- eject_d  output  1  dime eject pulse.
- eject_n  output  1  nickel eject pulse.
- eject_p  output  1  penny eject pulse.
- busy  output  1  high from the cycle after start accept through the DONE cycle.
- done  output  1  one-cycle pulse marking end of a transaction.
- aborted  output  1  set if the last transaction ended by abort; cleared on next start accept.
- dispensed  output  10  cents ejected in the current/last transaction.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all eject_*, busy, done and aborted = 0; dispensed=0; internal counts and timer = 0.
- All outputs are registered.
- States: IDLE, PICK, PULSE, GAP, DONE.
- IDLE:
  - start=1 at an edge: latch the four counts, clear dispensed and aborted, go to PICK.
  - start is ignored in every other state; input changes after the snapshot are ignored.
- PICK (1 cycle): select the highest nonzero denomination in the order Q, D, N, P.
  - If one is found, load timer=PULSE_CYC and go to PULSE.
  - If all counts are 0, go to DONE.
- PULSE:
  - Exactly the selected eject line is high for PULSE_CYC cycles; never more than one eject line is high at once.
  - On the last PULSE cycle: decrement the selected count; add 25/10/5/1 to dispensed; load timer=GAP_CYC; go to GAP.
- GAP: all eject lines low for GAP_CYC cycles, then go to PICK.
- DONE (1 cycle): done=1, busy=1; next state IDLE with busy=0.
- Latency:
  - start at edge k gives PICK in cycle k+1.
  - Each coin costs 1+PULSE_CYC+GAP_CYC cycles.
  - Total start-to-done = N*(1+PULSE_CYC+GAP_CYC)+2 cycles, where N is the total coin count.
- Abort:
  - abort=1 in PICK, PULSE or GAP: next state DONE; all eject lines low from the next cycle; aborted=1 with the done pulse.
  - A coin whose PULSE was cut short is not counted; a coin that completed PULSE is counted.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: start is accepted and abort is ignored.
- Width: dispensed max is 15*41=615 < 1024, so no overflow handling is needed.
- dispensed holds after done until the next start accept.
- Reset mid-transaction: immediate return to reset values; no done pulse.

Test Plan:
- PULSE_CYC=4, GAP_CYC=2; start with Q=1,D=1,N=0,P=2 -> eject_q high 4 cycles, then eject_d, then two eject_p pulses, each 4 high/2 low. done at cycle 4*7+2=30 after start. dispensed=37, aborted=0.
- Start with all counts 0 -> no eject activity; done in cycle k+2; busy high for cycles k+1..k+2; dispensed=0.
- Q=3 transaction; assert abort in the 2nd cycle of the second eject_q pulse -> eject_q low the next cycle; done one cycle later; aborted=1; dispensed=25.
- Pulse start again and change quarters during a busy transaction -> no restart, and the snapshot counts are used unchanged.
- Drop reset to 0 mid-PULSE -> eject_*, busy and dispensed go to 0 immediately (asynchronous); release and start P=1 -> normal single penny, dispensed=1.
- Q=15,D=15,N=15,P=15 -> 60 pulses in Q, D, N, P order; dispensed=615; never two eject lines high together.

Source files
------------

// File: rtl/coin_dispenser.sv
// coin_dispenser: ejects a snapshotted set of change coins one at a time,
// largest denomination first, with a fixed pulse/gap cadence per coin.
// Tracks cents dispensed and reports busy/done/aborted.
module coin_dispenser #(
    parameter int PULSE_CYC = 2500000,
    parameter int GAP_CYC   = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] quarters,
    input  logic [3:0] dimes,
    input  logic [3:0] nickels,
    input  logic [3:0] pennies,
    output logic       eject_q,
    output logic       eject_d,
    output logic       eject_n,
    output logic       eject_p,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [9:0] dispensed
);

    localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYC);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    localparam logic [1:0] SEL_Q = 2'd0;
    localparam logic [1:0] SEL_D = 2'd1;
    localparam logic [1:0] SEL_N = 2'd2;
    localparam logic [1:0] SEL_P = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_PULSE, S_GAP, S_DONE} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [1:0]    sel, sel_nx;
    logic [3:0]    cnt_q, cnt_d, cnt_n, cnt_p;
    logic [3:0]    cq_nx, cd_nx, cn_nx, cp_nx;
    logic [9:0]    disp_nx;
    logic          abrt_nx;

    // Next-state: walk the snapshot counts, one coin per PICK/PULSE/GAP round.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        sel_nx   = sel;
        cq_nx    = cnt_q;
        cd_nx    = cnt_d;
        cn_nx    = cnt_n;
        cp_nx    = cnt_p;
        disp_nx  = dispensed;
        abrt_nx  = aborted;
        case (state)
            S_IDLE: begin
                // start wins over a simultaneous abort here
                if (start) begin
                    cq_nx    = quarters;
                    cd_nx    = dimes;
                    cn_nx    = nickels;
                    cp_nx    = pennies;
                    disp_nx  = '0;
                    abrt_nx  = 1'b0;
                    state_nx = S_PICK;
                end
            end
            S_PICK: begin
                if (abort) begin
                    state_nx = S_DONE;
                    abrt_nx  = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    sel_nx = SEL_Q; timer_nx = T_PULSE; state_nx = S_PULSE;
                end else if (cnt_d != 4'd0) begin
                    sel_nx = SEL_D; timer_nx = T_PULSE; state_nx = S_PULSE;
                end else if (cnt_n != 4'd0) begin
                    sel_nx = SEL_N; timer_nx = T_PULSE; state_nx = S_PULSE;
                end else if (cnt_p != 4'd0) begin
                    sel_nx = SEL_P; timer_nx = T_PULSE; state_nx = S_PULSE;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_PULSE: begin
                // A coin that has held its full pulse is counted even if
                // abort lands on that final cycle; a cut-short one is not.
                if (timer == T_ONE) begin
                    case (sel)
                        SEL_Q:   begin cq_nx = cnt_q - 4'd1; disp_nx = dispensed + 10'd25; end
                        SEL_D:   begin cd_nx = cnt_d - 4'd1; disp_nx = dispensed + 10'd10; end
                        SEL_N:   begin cn_nx = cnt_n - 4'd1; disp_nx = dispensed + 10'd5;  end
                        default: begin cp_nx = cnt_p - 4'd1; disp_nx = dispensed + 10'd1;  end
                    endcase
                    timer_nx = T_GAP;
                    state_nx = S_GAP;
                end else begin
                    timer_nx = timer - T_ONE;
                end
                if (abort) begin
                    state_nx = S_DONE;
                    abrt_nx  = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_nx = S_DONE;
                    abrt_nx  = 1'b1;
                end else if (timer == T_ONE) begin
                    state_nx = S_PICK;
                end else begin
                    timer_nx = timer - T_ONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            sel       <= SEL_Q;
            cnt_q     <= '0;
            cnt_d     <= '0;
            cnt_n     <= '0;
            cnt_p     <= '0;
            dispensed <= '0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eject_q   <= 1'b0;
            eject_d   <= 1'b0;
            eject_n   <= 1'b0;
            eject_p   <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            sel       <= sel_nx;
            cnt_q     <= cq_nx;
            cnt_d     <= cd_nx;
            cnt_n     <= cn_nx;
            cnt_p     <= cp_nx;
            dispensed <= disp_nx;
            aborted   <= abrt_nx;
            busy      <= (state_nx != S_IDLE);
            done      <= (state_nx == S_DONE);
            eject_q   <= (state_nx == S_PULSE) && (sel_nx == SEL_Q);
            eject_d   <= (state_nx == S_PULSE) && (sel_nx == SEL_D);
            eject_n   <= (state_nx == S_PULSE) && (sel_nx == SEL_N);
            eject_p   <= (state_nx == S_PULSE) && (sel_nx == SEL_P);
        end
    end

endmodule

// File: tb/tb_coin_dispenser.sv
// tb_coin_dispenser: table-driven transactions with a per-cycle pulse
// monitor, plus hand sequences for reset, idle abort and mid-pulse reset.
module tb_coin_dispenser;

    localparam int PULSE = 4;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] quarters = '0, dimes = '0, nickels = '0, pennies = '0;
    logic       eject_q, eject_d, eject_n, eject_p;
    logic       busy, done, aborted;
    logic [9:0] dispensed;

    int checks = 0;
    int failures = 0;

    coin_dispenser #(.PULSE_CYC(PULSE), .GAP_CYC(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .quarters(quarters), .dimes(dimes), .nickels(nickels), .pennies(pennies),
        .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n), .eject_p(eject_p),
        .busy(busy), .done(done), .aborted(aborted), .dispensed(dispensed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q, d, n, p;
        int         abort_at;       // cycle after start in which abort is high (-1: never)
        bit         abort_on_start; // abort high together with start
        int         poke_at;        // cycle where start/quarters are poked mid-transaction
        int         exp_lat;        // cycles from start edge to the done cycle
        int         exp_disp;
        bit         exp_abrt;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one transaction and watch it cycle by cycle until done.
    task automatic run_vec(input int idx, input vec_t v);
        int c, lat, npulse, hi_len, lo_len, rank, prev_rank;
        int multi_err, order_err, width_err, gap_err, abort_err;
        logic [3:0] ej;
        @(negedge clk);
        quarters = v.q; dimes = v.d; nickels = v.n; pennies = v.p;
        start = 1'b1;
        abort = v.abort_on_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        // scramble inputs: the snapshot must be what gets dispensed
        quarters = ~v.q; dimes = ~v.d; nickels = ~v.n; pennies = ~v.p;
        c = 1; lat = -1; npulse = 0; hi_len = 0; lo_len = 0; prev_rank = 0;
        multi_err = 0; order_err = 0; width_err = 0; gap_err = 0; abort_err = 0;
        chk($sformatf("v%0d_busy_first", idx), busy, 1);
        chk($sformatf("v%0d_aborted_clr", idx), aborted, 0);
        chk($sformatf("v%0d_disp_clr", idx), dispensed, 0);
        while (c <= 500) begin
            ej = {eject_q, eject_d, eject_n, eject_p};
            if ($countones(ej) > 1) multi_err++;
            if (v.abort_at >= 0 && c == v.abort_at + 1 && ej != 4'b0) abort_err++;
            if (ej != 4'b0) begin
                if (hi_len == 0) begin
                    npulse++;
                    rank = eject_q ? 0 : eject_d ? 1 : eject_n ? 2 : 3;
                    if (rank < prev_rank) order_err++;
                    if (npulse > 1 && lo_len != GAP + 1) gap_err++;
                    prev_rank = rank;
                end
                hi_len++;
                lo_len = 0;
            end else begin
                if (hi_len > 0 && (v.abort_at < 0 || c <= v.abort_at) && hi_len != PULSE)
                    width_err++;
                hi_len = 0;
                lo_len++;
            end
            if (done) begin
                lat = c;
                break;
            end
            abort = (c == v.abort_at);
            if (v.poke_at >= 0 && (c == v.poke_at || c == v.poke_at + 1)) begin
                start = 1'b1;
                quarters = 4'd15;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        abort = 1'b0;
        start = 1'b0;
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_busy_done", idx), busy, 1);
        chk($sformatf("v%0d_dispensed", idx), dispensed, v.exp_disp);
        chk($sformatf("v%0d_aborted", idx), aborted, v.exp_abrt);
        chk($sformatf("v%0d_pulses", idx), npulse, v.exp_pulses);
        chk($sformatf("v%0d_onehot_errs", idx), multi_err, 0);
        chk($sformatf("v%0d_order_errs", idx), order_err, 0);
        chk($sformatf("v%0d_width_errs", idx), width_err, 0);
        chk($sformatf("v%0d_gap_errs", idx), gap_err, 0);
        chk($sformatf("v%0d_abort_errs", idx), abort_err, 0);
        @(negedge clk);
        chk($sformatf("v%0d_done_1cyc", idx), done, 0);
        chk($sformatf("v%0d_busy_idle", idx), busy, 0);
        chk($sformatf("v%0d_disp_hold", idx), dispensed, v.exp_disp);
    endtask

    initial begin
        vec_t pv;
        //            q      d      n      p     ab_at onst poke lat  disp abrt pulses
        vecs[0] = '{4'd1,  4'd1,  4'd0,  4'd2,  -1, 1'b0, -1,  30,  37, 1'b0, 4};
        vecs[1] = '{4'd0,  4'd0,  4'd0,  4'd0,  -1, 1'b0, -1,   2,   0, 1'b0, 0};
        vecs[2] = '{4'd3,  4'd0,  4'd0,  4'd0,  10, 1'b0, -1,  11,  25, 1'b1, 2};
        vecs[3] = '{4'd2,  4'd0,  4'd0,  4'd0,  -1, 1'b0,  3,  16,  50, 1'b0, 2};
        vecs[4] = '{4'd15, 4'd15, 4'd15, 4'd15, -1, 1'b0, -1, 422, 615, 1'b0, 60};
        vecs[5] = '{4'd0,  4'd0,  4'd1,  4'd3,  -1, 1'b1, -1,  30,   8, 1'b0, 4};
        vecs[6] = '{4'd2,  4'd0,  4'd0,  4'd0,   6, 1'b0, -1,   7,  25, 1'b1, 1};
        vecs[7] = '{4'd1,  4'd1,  4'd0,  4'd0,   8, 1'b0, -1,   9,  25, 1'b1, 1};

        // reset state
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ejects", int'({eject_q, eject_d, eject_n, eject_p}), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_disp", dispensed, 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // abort while idle: nothing moves, last results are kept
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);
        chk("idle_abort_aborted", aborted, 1);
        chk("idle_abort_disp", dispensed, 25);

        // reset during the second quarter pulse
        @(negedge clk);
        quarters = 4'd2; dimes = 4'd0; nickels = 4'd0; pennies = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_pre_ejq", eject_q, 1);
        chk("midrst_pre_disp", dispensed, 25);
        reset = 1'b0;
        #1;
        chk("midrst_ejq", eject_q, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_disp", dispensed, 0);
        @(negedge clk);
        chk("midrst_no_done", done, 0);
        reset = 1'b1;
        pv = '{4'd0, 4'd0, 4'd0, 4'd1, -1, 1'b0, -1, 9, 1, 1'b0, 1};
        run_vec(8, pv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
